pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline boundary register, the generalised successor to the fixed two-field fetch/decode latch. It carries `LANES` independent payload lanes of `DATA_W` bits each. Each lane has a valid bit. Stall (hold) and flush (bubble insert) follow a fixed priority. A saturating stall-duration monitor flags a stage held too long. The block sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit.

## Interface
- `DATA_W`, 32: payload width per lane.
- `LANES`, 2: number of payload lanes (e.g. PC+4 and instruction = 2).
- `NOP_VALUE`, 0: value loaded into every lane on flush or reset (`DATA_W` bits).
- `STALL_LIMIT`, 15: consecutive stall cycles after which `stall_timeout` asserts (1..255).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  write enable; 0 = stall (hold current contents).
- `flush`  in  1  synchronous clear; inserts a bubble.
- `valid_in`  in  1  upstream stage holds a real instruction.
- `d`  in  `LANES*DATA_W`  packed lane payloads; lane i = `d[i*DATA_W +: DATA_W]`.
- `q`  out  `LANES*DATA_W`  registered payloads, same packing.
- `valid_out`  out  1  registered valid.
- `stall_timeout`  out  1  held stall exceeded `STALL_LIMIT`.
- `stall_cnt`  out  8  current consecutive-stall count (saturating).

## Operation
- Per-cycle priority at the rising edge is `rst`==0 > `flush` > `en`==0 > load.
- Reset: every lane of `q` = `NOP_VALUE`, `valid_out`=0, `stall_cnt`=0, `stall_timeout`=0.
- Flush: all lanes ← `NOP_VALUE` and `valid_out`←0, regardless of `en`. `stall_cnt` clears.
- Stall (`en`=0, no flush): `q` and `valid_out` hold. `stall_cnt` increments and saturates at 255.
- Load (`en`=1, no flush): `q`←`d`, `valid_out`←`valid_in`. `stall_cnt` clears.
- One flush/enable pair is shared by all lanes. Lanes are never updated partially. Every lane, including the instruction lane, honours flush.
- `stall_timeout` is registered and equals (`stall_cnt` ≥ `STALL_LIMIT`) after the update. It is sticky until the next load, flush or reset.
- A stall counts only while `valid_out`=1. Holding a bubble does not increment `stall_cnt`.

## Timing
- Latency is 1 cycle from `d`/`valid_in` to `q`/`valid_out`. There is no combinational path from input to output.
- `flush` and `en` sampled in cycle N take effect on outputs from cycle N+1.
- Reset asserted mid-stall clears the counter and timeout in the same edge. The first load after reset release happens at the first edge with `rst`=1 and `en`=1.
- Simultaneous `flush`=1 and `en`=0: flush wins, and the bubble is inserted even while stalled.
- `stall_cnt` saturates at 255 and does not wrap. `stall_timeout` remains 1 while saturated.

## Configuration
- `PIPE_STAGE_PERF_EN` defined: adds output `flush_count` (16 bit), a saturating count of flush events since reset (0 on reset, stops at 0xFFFF), and output `bubble_cycles` (16 bit, saturating), incremented every cycle `valid_out`=0 after reset.
- Not defined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `d`=all-ones, `valid_in`=1 → `q`=`NOP_VALUE` in every lane, `valid_out`=0, `stall_cnt`=0.
- Load/stall: load `d`={0x00000004, 0x8C220000}, `valid_in`=1, then `en`=0 for 3 cycles with new `d` → `q` holds {0x4, 0x8C220000}, `stall_cnt`=3.
- Flush beats stall: `en`=0 and `flush`=1 in the same cycle → next cycle all lanes = `NOP_VALUE`, `valid_out`=0, `stall_cnt`=0.
- Timeout: `STALL_LIMIT`=4, valid content, `en`=0 for 4 cycles → `stall_timeout`=1 on the 4th post-edge. One load cycle → `stall_timeout`=0.
- Bubble stall: after a flush, `en`=0 for 10 cycles → `stall_cnt` stays 0 and `stall_timeout` stays 0.
- Perf (with `PIPE_STAGE_PERF_EN`): 3 flushes separated by loads → `flush_count`=3. `bubble_cycles` counts the cycles with `valid_out`=0 exactly.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline boundary register. Carries LANES payload lanes of
// DATA_W bits plus one shared valid bit between two pipeline stages. The
// hazard unit drives en (0 = stall/hold) and flush (insert a bubble). A
// saturating monitor counts consecutive stall cycles of valid content and
// raises a sticky stall_timeout once STALL_LIMIT is reached.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, adds flush_count and bubble_cycles performance counters.
//
// Parameters
//   DATA_W      payload width per lane
//   LANES       number of payload lanes
//   NOP_VALUE   value loaded into every lane on flush or reset
//   STALL_LIMIT consecutive stall cycles that trip stall_timeout (1..255)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-low reset
//   en             in   write enable; 0 holds current contents
//   flush          in   insert a bubble (beats en=0)
//   valid_in       in   upstream stage holds a real instruction
//   d              in   packed lane payloads, lane i = d[i*DATA_W +: DATA_W]
//   q              out  registered payloads, same packing
//   valid_out      out  registered valid
//   stall_timeout  out  sticky: held stall reached STALL_LIMIT
//   stall_cnt      out  consecutive-stall count, saturates at 255
//   flush_count    out  (PIPE_STAGE_PERF_EN) saturating flush event count
//   bubble_cycles  out  (PIPE_STAGE_PERF_EN) saturating count of cycles
//                       with valid_out = 0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W      = 32,
    parameter int                 LANES       = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE   = '0,
    parameter int                 STALL_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [LANES*DATA_W-1:0]   d,
    output logic [LANES*DATA_W-1:0]   q,
    output logic                      valid_out,
    output logic                      stall_timeout,
    output logic [7:0]                stall_cnt
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]               flush_count,
    output logic [15:0]               bubble_cycles
`endif
);

    localparam logic [7:0] LIMIT   = 8'(STALL_LIMIT);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Decoded per-cycle action; flush outranks a stall.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } action_e;

    action_e act;

    logic [LANES-1:0][DATA_W-1:0] lane_q, lane_d;
    logic                         valid_q, valid_d;
    logic [7:0]                   stall_cnt_q, stall_cnt_d;
    logic                         timeout_q, timeout_d;

    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (!en) begin
            act = ACT_HOLD;
        end
    end

    // All lanes share one action so a partial update can never happen.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_d[gi] = (act == ACT_BUBBLE) ? NOP_VALUE :
                                (act == ACT_LOAD)   ? d[gi*DATA_W +: DATA_W] :
                                                      lane_q[gi];
        end
    endgenerate

    always_comb begin
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;
        case (act)
            ACT_BUBBLE: begin
                valid_d     = 1'b0;
                stall_cnt_d = '0;
                timeout_d   = 1'b0;
            end
            ACT_HOLD: begin
                // Holding a bubble is harmless and is not counted.
                if (valid_q && (stall_cnt_q != CNT_MAX)) begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
                timeout_d = timeout_q | (stall_cnt_d >= LIMIT);
            end
            default: begin
                valid_d     = valid_in;
                stall_cnt_d = '0;
                timeout_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q      <= {LANES{NOP_VALUE}};
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign q             = lane_q;
    assign valid_out     = valid_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = timeout_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] bubble_q, bubble_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        bubble_d    = bubble_q;
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        // Counts the cycle that is ending with an empty stage.
        if (!valid_q && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt_q <= '0;
            bubble_q    <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            bubble_q    <= bubble_d;
        end
    end

    assign flush_count   = flush_cnt_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int          DW  = 32;
    localparam int          LN  = 2;
    localparam int          LIM = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic [63:0]   d = '0;
    logic [63:0]   q;
    logic          valid_out;
    logic          stall_timeout;
    logic [7:0]    stall_cnt;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   flush_count;
    logic [15:0]   bubble_cycles;
`endif

    pipe_stage_reg #(
        .DATA_W      (DW),
        .LANES       (LN),
        .NOP_VALUE   (NOP),
        .STALL_LIMIT (LIM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .valid_in      (valid_in),
        .d             (d),
        .q             (q),
        .valid_out     (valid_out),
        .stall_timeout (stall_timeout),
        .stall_cnt     (stall_cnt)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .flush_count   (flush_count),
        .bubble_cycles (bubble_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] m_q;
    bit          m_v;
    int          m_cnt;
    bit          m_to;
    int          m_fc;
    int          m_bc;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (txn %0d)", tag, obs, exp, n_txn);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit f, input bit vi,
                        input logic [63:0] dv, input string tag);
        @(negedge clk);
        rst = r; en = e; flush = f; valid_in = vi; d = dv;
        @(posedge clk);
        if (!r) begin
            m_q   = {LN{NOP}};
            m_v   = 1'b0;
            m_cnt = 0;
            m_to  = 1'b0;
            m_fc  = 0;
            m_bc  = 0;
        end else begin
            if (!m_v) m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
            if (f) begin
                m_fc  = (m_fc < 65535) ? m_fc + 1 : 65535;
                m_q   = {LN{NOP}};
                m_v   = 1'b0;
                m_cnt = 0;
                m_to  = 1'b0;
            end else if (!e) begin
                if (m_v) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_cnt >= LIM) m_to = 1'b1;
            end else begin
                m_q   = dv;
                m_v   = vi;
                m_cnt = 0;
                m_to  = 1'b0;
            end
        end
        #1;
        n_txn++;
        $display("txn %0d %s rst=%0b en=%0b flush=%0b vin=%0b d=%h -> q=%h v=%0b cnt=%0d to=%0b",
                 n_txn, tag, r, e, f, vi, dv, q, valid_out, stall_cnt, stall_timeout);
        chk({tag, ".q"}, q, m_q);
        chk({tag, ".valid_out"}, 64'(valid_out), 64'(m_v));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
        chk({tag, ".stall_timeout"}, 64'(stall_timeout), 64'(m_to));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, ".flush_count"}, 64'(flush_count), 64'(m_fc));
        chk({tag, ".bubble_cycles"}, 64'(bubble_cycles), 64'(m_bc));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ones;
        logic [63:0] ld;
        ones = '1;
        ld   = {32'h0000_0004, 32'h8C22_0000};

        // Reset for two cycles with garbage on the inputs
        step(0, 1, 0, 1, ones, "reset");
        step(0, 1, 0, 1, ones, "reset");

        // Load then stall three cycles with new data offered
        step(1, 1, 0, 1, ld, "load");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, ones, "stall");

        // Flush while stalled
        step(1, 0, 1, 1, ones, "flush_stall");

        // Timeout at exactly LIM stall cycles, cleared by one load
        step(1, 1, 0, 1, ld, "load");
        for (int i = 0; i < LIM; i++) step(1, 0, 0, 0, ones, "stall_to");
        step(1, 1, 0, 1, ld, "load_clr");

        // Stalling a bubble never counts
        step(1, 0, 1, 1, ld, "flush");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, ones, "bubble_stall");

        // Three flushes separated by loads
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, {$urandom, $urandom}, "load");
            step(1, 1, 1, 1, ones, "flush");
        end

        // Saturation of the stall counter
        step(1, 1, 0, 1, ld, "load");
        for (int i = 0; i < 260; i++) step(1, 0, 0, 1, ones, "sat");

        // Reset in the middle of a stall
        step(0, 0, 0, 1, ones, "reset_mid");
        step(1, 0, 0, 1, ones, "post_rst_stall");
        step(1, 1, 0, 1, ld, "first_load");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, e, f, vi;
            r  = ($urandom_range(0, 199) != 0);
            f  = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 9) < 4);
            vi = ($urandom_range(0, 3) != 0);
            step(r, e, f, vi, {$urandom, $urandom}, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
